// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - shared constants and helpers for the dff_chain register pipeline
package dff_pkg;

   // Every data bit resets to this value; replicate to the needed width.
   localparam logic RST_DATA_BIT = 1'b0;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_stage.sv
// rtl/dff_stage.sv - one pipeline stage: data flop plus valid flop with load and valid-clear
module dff_stage
   import dff_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             valid_nxt_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   // Clear wins over load and leaves the data word untouched.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         data_d  = data_i;
         valid_d = valid_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= {WIDTH{RST_DATA_BIT}};
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign valid_nxt_o = valid_d;

endmodule

// File: rtl/dff_chain.sv
// rtl/dff_chain.sv - DEPTH-stage enabled register chain with valid flags; DFF_CHAIN_TAPS_EN adds taps
module dff_chain
   import dff_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [WIDTH-1:0]               d,
   input  logic                           d_valid,
   input  logic                           en,
   input  logic                           flush,
   output logic [WIDTH-1:0]               q,
   output logic [WIDTH-1:0]               qbar,
   output logic                           q_valid,
`ifdef DFF_CHAIN_TAPS_EN
   output logic [count_width(DEPTH)-1:0]  count,
   output logic [WIDTH*DEPTH-1:0]         taps
`else
   output logic [count_width(DEPTH)-1:0]  count
`endif
);

   localparam int CW = count_width(DEPTH);

   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH-1:0] valid_nxt;
   logic             load;
   logic [CW-1:0]    count_q, count_d;

   assign load = en & ~flush;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [WIDTH-1:0] src_data;
      logic             src_valid;

      if (k == 0) begin : g_head
         assign src_data  = d;
         assign src_valid = d_valid;
      end else begin : g_body
         assign src_data  = stage_data[k-1];
         assign src_valid = stage_valid[k-1];
      end

      dff_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk         (clk),
         .rst_n       (rst_n),
         .load_i      (load),
         .clr_i       (flush),
         .data_i      (src_data),
         .valid_i     (src_valid),
         .data_o      (stage_data[k]),
         .valid_o     (stage_valid[k]),
         .valid_nxt_o (valid_nxt[k])
      );
   end

   // Count tracks the valid vector the stages are about to load, so both land on the same edge.
   always_comb begin
      count_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         count_d = count_d + CW'(valid_nxt[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign q       = stage_data[DEPTH-1];
   assign qbar    = ~stage_data[DEPTH-1];
   assign q_valid = stage_valid[DEPTH-1];
   assign count   = count_q;

`ifdef DFF_CHAIN_TAPS_EN
   for (genvar k = 0; k < DEPTH; k++) begin : g_taps
      assign taps[k*WIDTH +: WIDTH] = stage_data[k];
   end
`endif

endmodule

// File: tb/tb_dff_chain.sv
// tb/tb_dff_chain.sv - randomized self-checking bench for dff_chain (WIDTH=8, DEPTH=4)
module tb_dff_chain;

   localparam int W = 8;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] d = '0;
   logic         d_valid = 1'b0;
   logic         en = 1'b0;
   logic         flush = 1'b0;
   logic [W-1:0] q, qbar;
   logic         q_valid;
   logic [2:0]   count;
`ifdef DFF_CHAIN_TAPS_EN
   logic [W*N-1:0] taps;
`endif

   int total = 0;
   int bad = 0;

   logic [W-1:0] m_data [N];
   logic         m_valid [N];

   always #5 clk = ~clk;

   dff_chain #(.WIDTH(W), .DEPTH(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (d),
      .d_valid (d_valid),
      .en      (en),
      .flush   (flush),
      .q       (q),
      .qbar    (qbar),
      .q_valid (q_valid),
`ifdef DFF_CHAIN_TAPS_EN
      .count   (count),
      .taps    (taps)
`else
      .count   (count)
`endif
   );

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         m_data[k]  = '0;
         m_valid[k] = 1'b0;
      end
   endtask

   task automatic model_edge(input logic [W-1:0] dd, input logic dv, input logic e, input logic fl);
      if (fl) begin
         for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
      end else if (e) begin
         for (int k = N - 1; k > 0; k--) begin
            m_data[k]  = m_data[k-1];
            m_valid[k] = m_valid[k-1];
         end
         m_data[0]  = dd;
         m_valid[0] = dv;
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int k = 0; k < N; k++) c += int'(m_valid[k]);
      return c;
   endfunction

   task automatic clk_edge(input logic [W-1:0] dd, input logic dv, input logic e, input logic fl);
      d = dd; d_valid = dv; en = e; flush = fl;
      @(posedge clk);
      model_edge(dd, dv, e, fl);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      #1;
      total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", q); end
      total++; if (qbar !== 8'hFF) begin bad++; $display("FAIL reset_qbar got=%h want=ff", qbar); end
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_qv got=%b want=0", q_valid); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
   endtask

   task automatic test_streaming();
      logic [W-1:0] words [4];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         clk_edge(words[i], 1'b1, 1'b1, 1'b0);
         total++;
         if (count !== 3'(i + 1)) begin bad++; $display("FAIL stream_count edge=%0d got=%0d want=%0d", i + 1, count, i + 1); end
      end
      total++; if (q !== 8'h11 || q_valid !== 1'b1) begin bad++; $display("FAIL stream_first got=%h/%b want=11/1", q, q_valid); end
      for (int i = 1; i < 4; i++) begin
         clk_edge(8'h00, 1'b0, 1'b1, 1'b0);
         total++;
         if (q !== words[i] || q_valid !== 1'b1) begin bad++; $display("FAIL stream_next i=%0d got=%h/%b want=%h/1", i, q, q_valid, words[i]); end
      end
   endtask

   task automatic test_stall();
      int seen = 0;
      int seen_at = -1;
      clk_edge(8'h00, 1'b0, 1'b0, 1'b1);
      clk_edge(8'hA5, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         clk_edge(8'h3C, 1'b1, 1'b0, 1'b0);
         total++;
         if (q !== m_data[N-1] || q_valid !== 1'b0 || count !== 3'd1) begin
            bad++; $display("FAIL stall_hold cyc=%0d got=%h/%b/%0d want=%h/0/1", i, q, q_valid, count, m_data[N-1]);
         end
      end
      for (int i = 1; i <= 8; i++) begin
         clk_edge(8'h00, 1'b0, 1'b1, 1'b0);
         if (q === 8'hA5 && q_valid === 1'b1) begin seen++; seen_at = i; end
      end
      total++; if (seen != 1) begin bad++; $display("FAIL stall_dup got=%0d want=1", seen); end
      total++; if (seen_at != 3) begin bad++; $display("FAIL stall_exit got=%0d want=3", seen_at); end
   endtask

   task automatic test_flush();
      int leaked = 0;
      clk_edge(8'h31, 1'b1, 1'b1, 1'b0);
      clk_edge(8'h32, 1'b1, 1'b1, 1'b0);
      clk_edge(8'h33, 1'b1, 1'b1, 1'b0);
      total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d want=3", count); end
      clk_edge(8'h5A, 1'b1, 1'b1, 1'b1);
      total++; if (count !== 3'd0 || q_valid !== 1'b0) begin bad++; $display("FAIL flush_clr got=%0d/%b want=0/0", count, q_valid); end
      total++; if (q !== m_data[N-1]) begin bad++; $display("FAIL flush_data got=%h want=%h", q, m_data[N-1]); end
      for (int i = 0; i < 6; i++) begin
         clk_edge(8'h00, 1'b0, 1'b1, 1'b0);
         if (q === 8'h5A && q_valid === 1'b1) leaked++;
      end
      total++; if (leaked != 0) begin bad++; $display("FAIL flush_leak got=%0d want=0", leaked); end
   endtask

   task automatic test_async_reset();
      clk_edge(8'h61, 1'b1, 1'b1, 1'b0);
      clk_edge(8'h62, 1'b1, 1'b1, 1'b0);
      clk_edge(8'h63, 1'b1, 1'b1, 1'b0);
      clk_edge(8'h64, 1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (q !== 8'h00 || qbar !== 8'hFF || q_valid !== 1'b0 || count !== 3'd0) begin
         bad++; $display("FAIL async_rst got=%h/%h/%b/%0d want=00/ff/0/0", q, qbar, q_valid, count);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      for (int i = 1; i <= 4; i++) begin
         clk_edge(i == 1 ? 8'h77 : 8'h00, i == 1, 1'b1, 1'b0);
         total++;
         if (count !== 3'd1) begin bad++; $display("FAIL async_restart_count edge=%0d got=%0d want=1", i, count); end
      end
      total++; if (q !== 8'h77 || q_valid !== 1'b1) begin bad++; $display("FAIL async_restart_q got=%h/%b want=77/1", q, q_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         clk_edge(W'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
         total++; if (q !== m_data[N-1]) begin bad++; $display("FAIL rnd_q cyc=%0d got=%h want=%h", i, q, m_data[N-1]); end
         total++; if (qbar !== ~m_data[N-1]) begin bad++; $display("FAIL rnd_qbar cyc=%0d got=%h want=%h", i, qbar, ~m_data[N-1]); end
         total++; if (q_valid !== m_valid[N-1]) begin bad++; $display("FAIL rnd_qv cyc=%0d got=%b want=%b", i, q_valid, m_valid[N-1]); end
         total++; if (int'(count) != model_count()) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, count, model_count()); end
      end
   endtask

`ifdef DFF_CHAIN_TAPS_EN
   task automatic test_taps();
      clk_edge(8'h01, 1'b1, 1'b1, 1'b0);
      clk_edge(8'h02, 1'b1, 1'b1, 1'b0);
      clk_edge(8'h03, 1'b1, 1'b1, 1'b0);
      clk_edge(8'h04, 1'b1, 1'b1, 1'b0);
      total++; if (taps !== 32'h01020304) begin bad++; $display("FAIL taps got=%h want=01020304", taps); end
      total++; if (q !== 8'h01 || qbar !== 8'hFE) begin bad++; $display("FAIL taps_qbar got=%h/%h want=01/fe", q, qbar); end
      #3;
      total++; if (qbar !== 8'hFE) begin bad++; $display("FAIL taps_qbar_late got=%h want=fe", qbar); end
   endtask
`endif

   initial begin
      model_clear();
      test_reset();
      test_streaming();
      test_stall();
      test_flush();
      test_async_reset();
      test_random();
`ifdef DFF_CHAIN_TAPS_EN
      test_taps();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
